// File: rtl/spi_cmd_master.sv
// spi_cmd_master: write-only SPI mode-0 master that frames one command word per
// valid/ready handshake with programmable CS setup, hold and idle-gap times.
module spi_cmd_master #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned CS_SETUP  = 2,
    parameter int unsigned CS_HOLD   = 2,
    parameter int unsigned CS_IDLE   = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              CLK50M,
    input  logic              RESET_N,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [DATA_W-1:0] CMD_DATA,
    output logic              SPI_CS,
    output logic              SPI_CLK,
    output logic              SPI_MOSI,
    output logic              BUSY,
    output logic              DONE
);

    localparam int unsigned MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned MAX_B = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_V = (MAX_C > DATA_W) ? MAX_C : DATA_W;
    localparam int unsigned CNT_W = $clog2(MAX_V + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CLK_LO,
        CLK_HI,
        HOLD,
        GAP
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [CNT_W-1:0]  bits, bits_nx;
    logic [DATA_W-1:0] shreg, shreg_nx, shifted;
    logic              mosi_nx;
    logic              done_nx;

    // Next-state, phase counter, bit counter, shift register and next MOSI value.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bits_nx  = bits;
        shreg_nx = shreg;
        mosi_nx  = SPI_MOSI;
        done_nx  = 1'b0;
        shifted  = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
        unique case (state)
            IDLE: begin
                if (CMD_VALID && CMD_READY) begin
                    state_nx = SETUP;
                    cnt_nx   = '0;
                    bits_nx  = CNT_W'(DATA_W);
                    shreg_nx = CMD_DATA;
                    mosi_nx  = MSB_FIRST ? CMD_DATA[DATA_W-1] : CMD_DATA[0];
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_nx = CLK_LO;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            CLK_LO: begin
                if (cnt == DIV_LAST) begin
                    state_nx = CLK_HI;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            CLK_HI: begin
                if (cnt == DIV_LAST) begin
                    cnt_nx   = '0;
                    bits_nx  = bits - 1'b1;
                    shreg_nx = shifted;
                    if (bits != CNT_W'(1)) begin
                        state_nx = CLK_LO;
                        mosi_nx  = MSB_FIRST ? shifted[DATA_W-1] : shifted[0];
                    end else begin
                        state_nx = HOLD;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nx = GAP;
                    cnt_nx   = '0;
                    mosi_nx  = 1'b0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == IDLE_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                mosi_nx  = 1'b0;
            end
        endcase
    end

    // FSM state and datapath registers.
    always_ff @(posedge CLK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            cnt   <= '0;
            bits  <= '0;
            shreg <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            bits  <= bits_nx;
            shreg <= shreg_nx;
        end
    end

    // Output registers decoded from the next state so they line up with the state register.
    always_ff @(posedge CLK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            CMD_READY <= 1'b1;
            SPI_CS    <= 1'b1;
            SPI_CLK   <= 1'b0;
            SPI_MOSI  <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            CMD_READY <= (state_nx == IDLE);
            SPI_CS    <= (state_nx == IDLE) || (state_nx == GAP);
            SPI_CLK   <= (state_nx == CLK_HI);
            SPI_MOSI  <= mosi_nx;
            BUSY      <= (state_nx != IDLE);
            DONE      <= done_nx;
        end
    end

endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: scenario tasks for the SPI command master; a default-parameter
// instance and a fast LSB-first instance are checked against frame timing formulas
// and a slave-side monitor that samples MOSI on SPI_CLK rising edges.
module tb_spi_cmd_master;

    localparam int unsigned AW = 16, AK = 4, AS = 2, AH = 2, AI = 2;
    localparam int unsigned A_CS_LEN = AS + 2 * AK * AW + AH;
    localparam int unsigned A_DONE   = A_CS_LEN + AI + 1;
    localparam int unsigned A_RISE1  = AS + AK + 1;
    localparam int unsigned BW = 8, BK = 1, BS = 1, BH = 1, BI = 1;
    localparam int unsigned B_DONE   = BS + 2 * BK * BW + BH + BI + 1;
    localparam int unsigned B_RISE1  = BS + BK + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic          a_valid = 1'b0;
    logic [AW-1:0] a_data  = '0;
    logic          a_ready, a_cs, a_sclk, a_mosi, a_busy, a_done;
    logic          b_valid = 1'b0;
    logic [BW-1:0] b_data  = '0;
    logic          b_ready, b_cs, b_sclk, b_mosi, b_busy, b_done;

    int unsigned cyc    = 0;
    int          passed = 0;
    int          total  = 0;

    spi_cmd_master dut_a (
        .CLK50M(clk), .RESET_N(rst_n), .CMD_VALID(a_valid), .CMD_READY(a_ready),
        .CMD_DATA(a_data), .SPI_CS(a_cs), .SPI_CLK(a_sclk), .SPI_MOSI(a_mosi),
        .BUSY(a_busy), .DONE(a_done)
    );

    spi_cmd_master #(
        .DATA_W(BW), .CLK_DIV(BK), .CS_SETUP(BS), .CS_HOLD(BH), .CS_IDLE(BI), .MSB_FIRST(1'b0)
    ) dut_b (
        .CLK50M(clk), .RESET_N(rst_n), .CMD_VALID(b_valid), .CMD_READY(b_ready),
        .CMD_DATA(b_data), .SPI_CS(b_cs), .SPI_CLK(b_sclk), .SPI_MOSI(b_mosi),
        .BUSY(b_busy), .DONE(b_done)
    );

    always #5 clk = ~clk;

    // Cycle index: the handshake cycle is the value seen while CMD_VALID&CMD_READY are sampled.
    always @(posedge clk) cyc <= cyc + 1;

    // Slave-side monitor state.
    logic          a_pclk = 1'b0, a_pcs = 1'b1, a_pmosi = 1'b0;
    logic          a_bits[$];
    logic [AW-1:0] a_rx[$];
    int unsigned   a_len[$], a_rise[$], a_fall[$], a_done_q[$];
    int            a_viol = 0;
    logic [AW-1:0] a_w;
    logic          b_pclk = 1'b0, b_pcs = 1'b1, b_pmosi = 1'b0;
    logic          b_bits[$];
    logic          b_lastbits[$];
    logic [BW-1:0] b_rx[$];
    int unsigned   b_rise[$], b_done_q[$];
    int            b_viol = 0;
    logic [BW-1:0] b_w;

    // Monitor for the MSB-first instance: sample on falling clk, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            a_bits.delete();
            a_pclk = 1'b0; a_pcs = 1'b1; a_pmosi = 1'b0;
        end else begin
            if (a_sclk && a_cs) a_viol++;
            if (a_pclk && a_sclk && (a_mosi !== a_pmosi)) a_viol++;
            if (!a_pclk && a_sclk) begin
                a_rise.push_back(cyc);
                a_bits.push_back(a_mosi);
            end
            if (a_pcs && !a_cs) a_fall.push_back(cyc);
            if (!a_pcs && a_cs) begin
                a_w = '0;
                foreach (a_bits[i]) a_w = {a_w[AW-2:0], a_bits[i]};
                a_rx.push_back(a_w);
                a_len.push_back(a_bits.size());
                a_bits.delete();
            end
            if (a_done) a_done_q.push_back(cyc);
            a_pclk = a_sclk; a_pcs = a_cs; a_pmosi = a_mosi;
        end
    end

    // Monitor for the LSB-first instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            b_bits.delete();
            b_pclk = 1'b0; b_pcs = 1'b1; b_pmosi = 1'b0;
        end else begin
            if (b_sclk && b_cs) b_viol++;
            if (b_pclk && b_sclk && (b_mosi !== b_pmosi)) b_viol++;
            if (!b_pclk && b_sclk) begin
                b_rise.push_back(cyc);
                b_bits.push_back(b_mosi);
            end
            if (!b_pcs && b_cs) begin
                b_w = '0;
                foreach (b_bits[i]) if (i < BW) b_w[i[2:0]] = b_bits[i];
                b_rx.push_back(b_w);
                b_lastbits = b_bits;
                b_bits.delete();
            end
            if (b_done) b_done_q.push_back(cyc);
            b_pclk = b_sclk; b_pcs = b_cs; b_pmosi = b_mosi;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        a_rx.delete(); a_len.delete(); a_rise.delete(); a_fall.delete(); a_done_q.delete();
        b_rx.delete(); b_rise.delete(); b_done_q.delete(); b_lastbits.delete();
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        total++; if (a_cs !== 1'b1) $display("FAIL reset_cs: got %b want 1", a_cs); else passed++;
        total++; if (a_sclk !== 1'b0) $display("FAIL reset_sclk: got %b want 0", a_sclk); else passed++;
        total++; if (a_mosi !== 1'b0) $display("FAIL reset_mosi: got %b want 0", a_mosi); else passed++;
        total++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", a_busy); else passed++;
        total++; if (a_done !== 1'b0) $display("FAIL reset_done: got %b want 0", a_done); else passed++;
        total++; if (b_cs !== 1'b1) $display("FAIL reset_b_cs: got %b want 1", b_cs); else passed++;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        total++; if (a_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", a_ready); else passed++;
        total++; if (b_ready !== 1'b1) $display("FAIL reset_b_ready: got %b want 1", b_ready); else passed++;
    endtask

    task automatic test_single();
        logic [AW-1:0] word;
        logic [AW-1:0] got;
        int unsigned   hs, rel;
        int            cs_lo, cs_first, cs_last, busy_err;
        word = 16'hA5C3;
        cs_lo = 0; cs_first = -1; cs_last = -1; busy_err = 0;
        clear_mon();
        step();
        a_valid = 1'b1; a_data = word;
        total++; if (a_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", a_ready); else passed++;
        hs = cyc;
        step();
        a_valid = 1'b0; a_data = ~word;
        repeat (A_DONE + 5) begin
            rel = cyc - hs;
            if (a_cs === 1'b0) begin
                cs_lo++;
                if (cs_first < 0) cs_first = int'(rel);
                cs_last = int'(rel);
            end
            if (a_busy !== 1'(rel < A_DONE)) busy_err++;
            step();
        end
        got = (a_rx.size() > 0) ? a_rx[0] : 'x;
        total++; if (got !== word) $display("FAIL single_word: got %h want %h", got, word); else passed++;
        total++; if (a_rise.size() != AW) $display("FAIL single_rises: got %0d want %0d", a_rise.size(), AW); else passed++;
        total++; if (a_rise.size() == 0 || a_rise[0] - hs != A_RISE1)
            $display("FAIL single_first_rise: got %0d want %0d", (a_rise.size() > 0) ? a_rise[0] - hs : 0, A_RISE1);
        else passed++;
        total++; if (cs_lo != A_CS_LEN) $display("FAIL single_cs_len: got %0d want %0d", cs_lo, A_CS_LEN); else passed++;
        total++; if (cs_first != 1) $display("FAIL single_cs_first: got %0d want 1", cs_first); else passed++;
        total++; if (cs_last != int'(A_CS_LEN)) $display("FAIL single_cs_last: got %0d want %0d", cs_last, A_CS_LEN); else passed++;
        total++; if (a_done_q.size() != 1) $display("FAIL single_done_count: got %0d want 1", a_done_q.size()); else passed++;
        total++; if (a_done_q.size() == 0 || a_done_q[0] - hs != A_DONE)
            $display("FAIL single_done_cycle: got %0d want %0d", (a_done_q.size() > 0) ? a_done_q[0] - hs : 0, A_DONE);
        else passed++;
        total++; if (busy_err != 0) $display("FAIL single_busy: got %0d bad cycles want 0", busy_err); else passed++;
    endtask

    task automatic test_back_to_back();
        int unsigned hs1, hs2;
        int          found, gap_busy;
        logic [AW-1:0] got0, got1;
        found = 0; gap_busy = 0; hs2 = 0;
        clear_mon();
        step();
        a_valid = 1'b1; a_data = 16'h0001;
        total++; if (a_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", a_ready); else passed++;
        hs1 = cyc;
        step();
        a_data = 16'h8000;
        for (int i = 0; i < 400 && found == 0; i++) begin
            if (a_cs === 1'b1 && a_busy === 1'b1) gap_busy++;
            if (a_ready === 1'b1) begin
                found = 1;
                hs2 = cyc;
            end else begin
                step();
            end
        end
        total++; if (found != 1) $display("FAIL b2b_timeout: got no second handshake want one"); else passed++;
        step();
        a_valid = 1'b0;
        repeat (A_DONE + 5) step();
        // Second handshake lands in the first DONE cycle; CS then falls the cycle after.
        total++; if (hs2 - hs1 != A_DONE) $display("FAIL b2b_hs_spacing: got %0d want %0d", hs2 - hs1, A_DONE); else passed++;
        total++; if (a_fall.size() != 2 || a_fall[1] - hs1 != A_DONE + 1)
            $display("FAIL b2b_cs_refall: got %0d want %0d", (a_fall.size() == 2) ? a_fall[1] - hs1 : 0, A_DONE + 1);
        else passed++;
        total++; if (gap_busy != int'(AI)) $display("FAIL b2b_gap: got %0d want %0d", gap_busy, AI); else passed++;
        got0 = (a_rx.size() > 0) ? a_rx[0] : 'x;
        got1 = (a_rx.size() > 1) ? a_rx[1] : 'x;
        total++; if (got0 !== 16'h0001) $display("FAIL b2b_word0: got %h want 0001", got0); else passed++;
        total++; if (got1 !== 16'h8000) $display("FAIL b2b_word1: got %h want 8000", got1); else passed++;
        total++; if (a_done_q.size() != 2) $display("FAIL b2b_done_count: got %0d want 2", a_done_q.size()); else passed++;
    endtask

    task automatic test_reset_midframe();
        int unsigned hs;
        logic [AW-1:0] got;
        clear_mon();
        step();
        a_valid = 1'b1; a_data = AW'($urandom);
        step();
        a_valid = 1'b0;
        repeat (A_RISE1 + 2 * AK * 7 - 1) step();
        total++; if (a_cs !== 1'b0) $display("FAIL midrst_pre_cs: got %b want 0", a_cs); else passed++;
        total++; if (a_sclk !== 1'b1) $display("FAIL midrst_pre_sclk: got %b want 1", a_sclk); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (a_cs !== 1'b1) $display("FAIL midrst_cs: got %b want 1", a_cs); else passed++;
        total++; if (a_sclk !== 1'b0) $display("FAIL midrst_sclk: got %b want 0", a_sclk); else passed++;
        total++; if (a_mosi !== 1'b0) $display("FAIL midrst_mosi: got %b want 0", a_mosi); else passed++;
        total++; if (a_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", a_busy); else passed++;
        step(); step();
        rst_n = 1'b1;
        step();
        total++; if (a_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", a_ready); else passed++;
        a_valid = 1'b1; a_data = 16'h1234;
        hs = cyc;
        step();
        a_valid = 1'b0;
        repeat (A_DONE + 5) step();
        got = (a_rx.size() > 0) ? a_rx[0] : 'x;
        total++; if (a_rx.size() != 1 || got !== 16'h1234) $display("FAIL midrst_word: got %h (%0d words) want 1234", got, a_rx.size()); else passed++;
        total++; if (a_done_q.size() != 1 || a_done_q[0] - hs != A_DONE)
            $display("FAIL midrst_done: got %0d pulses want 1 at %0d", a_done_q.size(), A_DONE);
        else passed++;
    endtask

    task automatic test_ignore_midframe();
        logic [AW-1:0] w1, got;
        w1 = AW'($urandom);
        clear_mon();
        step();
        a_valid = 1'b1; a_data = w1;
        step();
        a_valid = 1'b0;
        repeat (39) step();
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; a_data = ~w1;
            total++; if (a_ready !== 1'b0) $display("FAIL ignore_ready%0d: got %b want 0", i, a_ready); else passed++;
            step();
        end
        a_valid = 1'b0;
        repeat (A_DONE + 20) step();
        got = (a_rx.size() > 0) ? a_rx[0] : 'x;
        total++; if (got !== w1) $display("FAIL ignore_word: got %h want %h", got, w1); else passed++;
        total++; if (a_fall.size() != 1) $display("FAIL ignore_frames: got %0d want 1", a_fall.size()); else passed++;
        total++; if (a_done_q.size() != 1) $display("FAIL ignore_done: got %0d want 1", a_done_q.size()); else passed++;
    endtask

    task automatic test_small_lsb();
        logic [BW-1:0] word, got;
        int unsigned   hs;
        int            sp_err;
        word = 8'hB4;
        sp_err = 0;
        clear_mon();
        step();
        b_valid = 1'b1; b_data = word;
        total++; if (b_ready !== 1'b1) $display("FAIL lsb_ready: got %b want 1", b_ready); else passed++;
        hs = cyc;
        step();
        b_valid = 1'b0; b_data = ~word;
        repeat (B_DONE + 5) step();
        got = (b_rx.size() > 0) ? b_rx[0] : 'x;
        total++; if (got !== word) $display("FAIL lsb_word: got %h want %h", got, word); else passed++;
        for (int i = 0; i < int'(BW); i++) begin
            total++;
            if (b_lastbits.size() <= i || b_lastbits[i] !== word[i])
                $display("FAIL lsb_bit%0d: got %b want %b", i, (b_lastbits.size() > i) ? b_lastbits[i] : 1'bx, word[i]);
            else passed++;
        end
        total++; if (b_rise.size() != BW) $display("FAIL lsb_rises: got %0d want %0d", b_rise.size(), BW); else passed++;
        total++; if (b_rise.size() == 0 || b_rise[0] - hs != B_RISE1)
            $display("FAIL lsb_first_rise: got %0d want %0d", (b_rise.size() > 0) ? b_rise[0] - hs : 0, B_RISE1);
        else passed++;
        for (int i = 1; i < b_rise.size(); i++) if (b_rise[i] - b_rise[i-1] != 2 * BK) sp_err++;
        total++; if (sp_err != 0) $display("FAIL lsb_period: got %0d bad periods want 0", sp_err); else passed++;
        total++; if (b_done_q.size() != 1 || b_done_q[0] - hs != B_DONE)
            $display("FAIL lsb_done: got %0d pulses at %0d want 1 at %0d", b_done_q.size(),
                     (b_done_q.size() > 0) ? b_done_q[0] - hs : 0, B_DONE);
        else passed++;
    endtask

    task automatic test_random();
        logic [AW-1:0] exp_q[$];
        int unsigned   hs_q[$];
        logic [AW-1:0] w;
        int            gap, waited, tmo, dly_err, len_err;
        tmo = 0; dly_err = 0; len_err = 0;
        clear_mon();
        for (int n = 0; n < 200 && tmo == 0; n++) begin
            gap = int'($urandom_range(0, 4));
            repeat (gap) begin
                a_data = AW'($urandom);
                step();
            end
            w = AW'($urandom);
            a_valid = 1'b1; a_data = w;
            waited = 0;
            while (a_ready !== 1'b1 && waited < 400) begin
                step();
                waited++;
            end
            total++;
            if (waited >= 400) begin
                $display("FAIL random_timeout: word %0d not accepted within 400 cycles", n);
                tmo = 1;
            end else passed++;
            exp_q.push_back(w);
            hs_q.push_back(cyc);
            step();
            a_valid = 1'b0; a_data = AW'($urandom);
        end
        a_valid = 1'b0;
        repeat (A_DONE + 5) step();
        total++; if (a_rx.size() != exp_q.size()) $display("FAIL random_count: got %0d want %0d", a_rx.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < a_rx.size(); i++) begin
            total++; if (a_rx[i] !== exp_q[i]) $display("FAIL random_word%0d: got %h want %h", i, a_rx[i], exp_q[i]); else passed++;
        end
        for (int i = 0; i < hs_q.size() && i < a_done_q.size(); i++) if (a_done_q[i] - hs_q[i] != A_DONE) dly_err++;
        foreach (a_len[i]) if (a_len[i] != AW) len_err++;
        total++; if (dly_err != 0 || a_done_q.size() != hs_q.size())
            $display("FAIL random_done_timing: got %0d bad frames, %0d pulses want 0 bad, %0d pulses", dly_err, a_done_q.size(), hs_q.size());
        else passed++;
        total++; if (len_err != 0) $display("FAIL random_bitcount: got %0d bad frames want 0", len_err); else passed++;
    endtask

    task automatic test_protocol();
        total++; if (a_viol != 0) $display("FAIL protocol_a: got %0d violations want 0", a_viol); else passed++;
        total++; if (b_viol != 0) $display("FAIL protocol_b: got %0d violations want 0", b_viol); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_midframe();
        test_ignore_midframe();
        test_small_lsb();
        test_random();
        test_protocol();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_cmd_master.md
Name: spi_cmd_master

Overview:
- SPI mode-0 master that serialises command words onto the SPI_CS / SPI_CLK / SPI_MOSI link driven into the trigger-pulse SPI slave.
- Write-only link: no MISO.
- Sits on the host/test side of that link, e.g. a bench-controller FPGA or a loopback test harness in the same design.
- Accepts one word per valid/ready handshake and frames it with programmable CS setup, hold and idle-gap times.

Parameters:
- DATA_W, 16, bits per frame (>=1).
- CLK_DIV, 4, CLK50M cycles per SPI_CLK half-period (>=1); default gives 6.25 MHz.
- CS_SETUP, 2, cycles from CS falling to first SPI_CLK low phase start (>=1).
- CS_HOLD, 2, cycles from last SPI_CLK falling to CS rising (>=1).
- CS_IDLE, 2, minimum cycles CS stays high between frames (>=1).
- MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first.

Ports:
- CLK50M  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command word available.
- CMD_READY  out  1  block can accept a word; high only in IDLE.
- CMD_DATA  in  DATA_W  word to send; captured at handshake.
- SPI_CS  out  1  chip select, active low, idle high.
- SPI_CLK  out  1  serial clock, idle low.
- SPI_MOSI  out  1  serial data; changes only while SPI_CLK is low.
- BUSY  out  1  high from handshake cycle+1 until return to IDLE.
- DONE  out  1  one-cycle pulse on return to IDLE after a frame.

Behaviour:
- Reset, asynchronous and immediate, including mid-frame:
  - SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, BUSY=0, DONE=0.
  - Shift register and counters cleared; state=IDLE.
  - CMD_READY=1 on the first cycle after release.
- All outputs are registered; no combinational path from inputs to SPI pins.
- States: IDLE, SETUP, CLK_LO, CLK_HI, HOLD, GAP.
- IDLE: CMD_READY=1. When CMD_VALID&CMD_READY, latch CMD_DATA and go to SETUP. Next cycle: SPI_CS=0, SPI_MOSI=first bit, BUSY=1.
- SETUP: hold CS_SETUP cycles, then CLK_LO.
- CLK_LO: SPI_CLK=0 for CLK_DIV cycles, then CLK_HI.
  - MOSI is updated to the current bit on entry (the first bit is already presented from SETUP entry).
- CLK_HI: SPI_CLK=1 for CLK_DIV cycles.
  - On exit, the bit counter decrements and the shift register advances.
  - If bits remain, go to CLK_LO; otherwise go to HOLD.
- HOLD: SPI_CLK=0, SPI_CS=0 for CS_HOLD cycles; SPI_MOSI holds the last bit. Then GAP.
- GAP: SPI_CS=1, SPI_MOSI=0 for CS_IDLE cycles, then IDLE with DONE=1, BUSY=0, CMD_READY=1 in that same cycle.
- Frame timing (handshake at cycle 0):
  - SPI_CS low for cycles 1 .. CS_SETUP+2*CLK_DIV*DATA_W+CS_HOLD; defaults give 132 cycles (1..132).
  - DONE at cycle CS_SETUP+2*CLK_DIV*DATA_W+CS_HOLD+CS_IDLE+1 (defaults: 135).
  - Exactly DATA_W SPI_CLK rising edges per frame; first rising edge at cycle CS_SETUP+CLK_DIV+1.
- Bit order:
  - MSB_FIRST=1: bit DATA_W-1 first.
  - MSB_FIRST=0: bit 0 first.
- CMD_VALID while not in IDLE is ignored (CMD_READY=0); CMD_DATA changes after the handshake do not affect the frame.
- Back-to-back: if CMD_VALID is high in the DONE cycle, the handshake completes that cycle and CS falls the next cycle, so the minimum CS-high time is exactly CS_IDLE cycles.
- Counter widths are sized by $clog2 of the largest of CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE, DATA_W. No wrap-around occurs within legal parameter values.

Test Plan:
- Default params, single CMD_DATA=16'hA5C3 -> slave model sampling on SPI_CLK rise reads 16'hA5C3; 16 rising edges; CS low 132 cycles; DONE one pulse at cycle 135; BUSY high cycles 1..134.
- Two words 16'h0001, 16'h8000 with CMD_VALID held -> second handshake in first DONE cycle; CS high exactly 2 cycles between frames; both words received intact.
- Assert RESET_N low at bit 7 of a frame -> same cycle (async) SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, BUSY=0; after release a new word 16'h1234 transfers cleanly and no partial DONE is seen.
- Change CMD_DATA and pulse CMD_VALID mid-frame -> no handshake; transmitted word is the original; no extra frame.
- CLK_DIV=1, CS_SETUP=CS_HOLD=CS_IDLE=1, DATA_W=8, MSB_FIRST=0, data 8'hB4 -> 25 MHz SPI_CLK; slave reads LSB-first 0,0,1,0,1,1,0,1; DONE at cycle 20.
- Random words (>=200) with random CMD_VALID gaps -> scoreboard matches every word; MOSI never changes while SPI_CLK=1; SPI_CLK never high while SPI_CS=1.
